match_round_controller: RTL and testbench
=========================================

Name: match_round_controller

Overview:
- Parametrised successor to the fixed hold-to-reset timer and the single-round winner flag in the game top level.
- Runs a best-of-N match: intro countdown, fight with round clock, KO/timeout resolution, win tally, match over, hold-to-restart.
- Sits between HealthManagement and the physics/health/menu blocks. Drives their round reset and the player-input freeze.

Parameters:
- ROUNDS_TO_WIN, 2: round wins needed to take the match.
- MAX_ROUNDS, 5: hard round limit, draws included.
- ROUND_SECONDS, 60: round clock start value in seconds.
- TICKS_PER_SEC, 20: game ticks per second.
- INTRO_TICKS, 60: length of the intro phase in ticks.
- RESULT_TICKS, 40: length of the round-result phase in ticks.
- HOLD_TICKS, 40: ticks a restart/force input must be held.
- HEALTH_W, 9: health bus width.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk game-tick pulse (20 Hz).
- health_1  in  HEALTH_W  player 1 health.
- health_2  in  HEALTH_W  player 2 health.
- restart_req  in  1  level input (btnC); honoured only in MATCH_OVER.
- force_reset  in  1  level input (sw[0]); honoured in any phase.
- phase  out  2  0 INTRO, 1 FIGHT, 2 ROUND_END, 3 MATCH_OVER.
- freeze  out  1  high whenever phase != FIGHT.
- round_reset  out  1  one-clk pulse that restores health and positions.
- round_num  out  $clog2(MAX_ROUNDS+1)  current round number, starting at 1.
- wins_p1  out  $clog2(ROUNDS_TO_WIN+1)  player 1 round wins.
- wins_p2  out  $clog2(ROUNDS_TO_WIN+1)  player 2 round wins.
- seconds_left  out  7  round clock value.
- round_winner  out  2  00 none, 01 p1, 10 p2, 11 draw.
- match_winner  out  2  same encoding as round_winner.

Behaviour:
- Reset values (reset low, async):
  - phase = INTRO, freeze = 1, round_reset = 0.
  - round_num = 1, wins_p1 = wins_p2 = 0.
  - seconds_left = ROUND_SECONDS, round_winner = match_winner = 00.
  - All internal tick/hold counters = 0.
- Sequencing: all state updates occur on clk edges where tick = 1. The only exception is round_reset, which is a single clk-cycle pulse.
- INTRO:
  - Count INTRO_TICKS ticks, then move to FIGHT.
  - On entry to FIGHT: seconds_left = ROUND_SECONDS, sub-second counter = 0, round_winner = 00.
- FIGHT, evaluated each tick in this priority order:
  - Both health values = 0: result is draw (11).
  - health_1 = 0 only: result is p2 (10).
  - health_2 = 0 only: result is p1 (01).
  - Otherwise the sub-second counter advances. When it reaches TICKS_PER_SEC-1 it wraps to 0 and seconds_left decrements.
  - Timeout is when seconds_left reaches 0. Higher health wins; equal health is a draw.
  - On any result: latch round_winner, increment the matching wins counter (draws increment nothing), then move to ROUND_END.
- ROUND_END, after RESULT_TICKS ticks:
  - If wins_p1 or wins_p2 = ROUNDS_TO_WIN: move to MATCH_OVER with match_winner set to that player.
  - Else if round_num = MAX_ROUNDS: move to MATCH_OVER with match_winner decided by the higher win count; equal counts give 11.
  - Else: round_num++, phase = INTRO, round_reset pulses on the next clk.
- MATCH_OVER:
  - freeze stays 1 and the result holds indefinitely.
  - restart_req held for HOLD_TICKS consecutive ticks triggers a full match reset (below).
- Hold counters:
  - Sampled on ticks; increment while the input is high, clear on any tick where it is low.
  - Saturate at HOLD_TICKS.
  - Fire once per press; the input must drop before the counter can re-arm.
  - restart_req counter is cleared while phase != MATCH_OVER.
- Full match reset:
  - Same values as hardware reset, plus one round_reset pulse.
  - force_reset held for HOLD_TICKS triggers it from any phase and has priority over KO/timeout resolved on the same tick.
- round_reset: asserted for exactly one clk cycle, on the clk after the tick that enters INTRO via round advance or full match reset. Never asserted by hardware reset.
- Width rules:
  - Win counters saturate at ROUNDS_TO_WIN.
  - seconds_left never underflows; it stays at 0.
  - round_num never exceeds MAX_ROUNDS.
- A tick arriving while reset is low has no effect.

Test Plan (parameters: TICKS_PER_SEC=2, ROUND_SECONDS=3, INTRO_TICKS=2, RESULT_TICKS=2, HOLD_TICKS=3, ROUNDS_TO_WIN=2, MAX_ROUNDS=3):
- Power-up: release reset, health 100/100, 2 ticks -> phase 1, freeze 0, seconds_left 3. Next 2 ticks -> seconds_left 2.
- KO: health_2 = 0 during FIGHT, 1 tick -> round_winner 01, wins_p1 1, phase 2. After 2 ticks -> phase 0, round_num 2, exactly one round_reset pulse.
- Timeout: health 80/50 held through 6 fight ticks -> round_winner 01, seconds_left 0. Repeating this p1 win -> phase 3, match_winner 01.
- Double KO: health 0/0 on the same tick -> 11; wins unchanged. Three draws in a row -> phase 3, match_winner 11 at round_num 3.
- Force reset: force_reset high for 3 ticks mid-FIGHT while health_1 drops to 0 on the third tick -> full reset (phase 0, wins 0/0, round_num 1), no KO recorded. force_reset high for 2 ticks, low for 1, high for 2 -> no reset.
- Mid-count async reset: assert reset during ROUND_END with wins 1/0 -> all outputs immediately at reset values; no round_reset pulse.

Source files
------------

// File: rtl/match_round_controller.sv
// match_round_controller: best-of-N match sequencer for the game top level.
// Intro countdown, timed fight, KO/timeout tally, match over, hold-to-restart.
module match_round_controller #(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int ROUND_SECONDS = 60,
    parameter int TICKS_PER_SEC = 20,
    parameter int INTRO_TICKS   = 60,
    parameter int RESULT_TICKS  = 40,
    parameter int HOLD_TICKS    = 40,
    parameter int HEALTH_W      = 9
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               tick,
    input  logic [HEALTH_W-1:0]                health_1,
    input  logic [HEALTH_W-1:0]                health_2,
    input  logic                               restart_req,
    input  logic                               force_reset,
    output logic [1:0]                         phase,
    output logic                               freeze,
    output logic                               round_reset,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]    round_num,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] wins_p1,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] wins_p2,
    output logic [6:0]                         seconds_left,
    output logic [1:0]                         round_winner,
    output logic [1:0]                         match_winner
);

    localparam int RW       = $clog2(MAX_ROUNDS + 1);
    localparam int WW       = $clog2(ROUNDS_TO_WIN + 1);
    localparam int STEP_MAX = (INTRO_TICKS > RESULT_TICKS) ? INTRO_TICKS
                                                           : RESULT_TICKS;
    localparam int PW       = $clog2(STEP_MAX + 1);
    localparam int SW       = $clog2(TICKS_PER_SEC + 1);
    localparam int HW       = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] INTRO_LAST  = PW'(INTRO_TICKS - 1);
    localparam logic [PW-1:0] RESULT_LAST = PW'(RESULT_TICKS - 1);
    localparam logic [SW-1:0] SUB_LAST    = SW'(TICKS_PER_SEC - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_FULL   = HW'(HOLD_TICKS);
    localparam logic [WW-1:0] WIN_FULL    = WW'(ROUNDS_TO_WIN);
    localparam logic [RW-1:0] ROUND_LAST  = RW'(MAX_ROUNDS);
    localparam logic [RW-1:0] RN_FIRST    = RW'(1);
    localparam logic [6:0]    SEC_START   = 7'(ROUND_SECONDS);

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_P1   = 2'b01;
    localparam logic [1:0] R_P2   = 2'b10;
    localparam logic [1:0] R_DRAW = 2'b11;

    typedef enum logic [1:0] {
        INTRO      = 2'd0,
        FIGHT      = 2'd1,
        ROUND_END  = 2'd2,
        MATCH_OVER = 2'd3
    } phase_t;

    phase_t        state;
    logic [PW-1:0] step_cnt;
    logic [SW-1:0] sub_cnt;
    logic [HW-1:0] force_cnt;
    logic [HW-1:0] restart_cnt;

    logic          force_fire;
    logic          restart_fire;
    logic          full_reset;
    logic          ko_1;
    logic          ko_2;
    logic          ko_any;
    logic          sub_wrap;
    logic [6:0]    sec_next;
    logic [1:0]    fight_result;
    logic [1:0]    match_result;

    assign phase = state;

    // Hold-to-fire detection: fires on the tick the count reaches HOLD_TICKS
    always_comb begin
        force_fire   = tick && force_reset && (force_cnt == HOLD_LAST);
        restart_fire = tick && restart_req && (state == MATCH_OVER)
                       && (restart_cnt == HOLD_LAST);
        full_reset   = force_fire || restart_fire;
    end

    // Round resolution from health and the next round-clock value
    always_comb begin
        ko_1     = (health_1 == '0);
        ko_2     = (health_2 == '0);
        ko_any   = ko_1 || ko_2;
        sub_wrap = (sub_cnt == SUB_LAST);
        sec_next = seconds_left;
        if (sub_wrap && seconds_left != 7'd0)
            sec_next = seconds_left - 7'd1;
        fight_result = R_NONE;
        if (ko_1 && ko_2)
            fight_result = R_DRAW;
        else if (ko_1)
            fight_result = R_P2;
        else if (ko_2)
            fight_result = R_P1;
        else if (sec_next == 7'd0) begin
            if (health_1 > health_2)
                fight_result = R_P1;
            else if (health_2 > health_1)
                fight_result = R_P2;
            else
                fight_result = R_DRAW;
        end
    end

    // Match decision taken when the result display ends
    always_comb begin
        match_result = R_NONE;
        if (wins_p1 == WIN_FULL)
            match_result = R_P1;
        else if (wins_p2 == WIN_FULL)
            match_result = R_P2;
        else if (round_num == ROUND_LAST) begin
            if (wins_p1 > wins_p2)
                match_result = R_P1;
            else if (wins_p2 > wins_p1)
                match_result = R_P2;
            else
                match_result = R_DRAW;
        end
    end

    // force_reset hold counter; stays saturated until the switch drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            force_cnt <= '0;
        end else if (tick) begin
            if (!force_reset)
                force_cnt <= '0;
            else if (force_cnt != HOLD_FULL)
                force_cnt <= force_cnt + 1'b1;
        end
    end

    // restart_req hold counter; only armed while the match is over
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            restart_cnt <= '0;
        end else if (tick) begin
            if (!restart_req || state != MATCH_OVER)
                restart_cnt <= '0;
            else if (restart_cnt != HOLD_FULL)
                restart_cnt <= restart_cnt + 1'b1;
        end
    end

    // Match phase sequencer with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= INTRO;
            freeze       <= 1'b1;
            round_reset  <= 1'b0;
            round_num    <= RN_FIRST;
            wins_p1      <= '0;
            wins_p2      <= '0;
            seconds_left <= SEC_START;
            round_winner <= R_NONE;
            match_winner <= R_NONE;
            step_cnt     <= '0;
            sub_cnt      <= '0;
        end else begin
            round_reset <= 1'b0;
            if (full_reset) begin
                state        <= INTRO;
                freeze       <= 1'b1;
                round_reset  <= 1'b1;
                round_num    <= RN_FIRST;
                wins_p1      <= '0;
                wins_p2      <= '0;
                seconds_left <= SEC_START;
                round_winner <= R_NONE;
                match_winner <= R_NONE;
                step_cnt     <= '0;
                sub_cnt      <= '0;
            end else if (tick) begin
                unique case (state)
                    INTRO: begin
                        if (step_cnt == INTRO_LAST) begin
                            step_cnt     <= '0;
                            state        <= FIGHT;
                            freeze       <= 1'b0;
                            seconds_left <= SEC_START;
                            sub_cnt      <= '0;
                            round_winner <= R_NONE;
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    FIGHT: begin
                        if (!ko_any) begin
                            sub_cnt      <= sub_wrap ? '0 : sub_cnt + 1'b1;
                            seconds_left <= sec_next;
                        end
                        if (fight_result != R_NONE) begin
                            round_winner <= fight_result;
                            state        <= ROUND_END;
                            freeze       <= 1'b1;
                            step_cnt     <= '0;
                            if (fight_result == R_P1 && wins_p1 != WIN_FULL)
                                wins_p1 <= wins_p1 + 1'b1;
                            if (fight_result == R_P2 && wins_p2 != WIN_FULL)
                                wins_p2 <= wins_p2 + 1'b1;
                        end
                    end
                    ROUND_END: begin
                        if (step_cnt == RESULT_LAST) begin
                            step_cnt <= '0;
                            if (match_result != R_NONE) begin
                                state        <= MATCH_OVER;
                                match_winner <= match_result;
                            end else begin
                                round_num   <= round_num + 1'b1;
                                state       <= INTRO;
                                round_reset <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 1'b1;
                        end
                    end
                    MATCH_OVER: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_match_round_controller.sv
// tb_match_round_controller: directed test-plan scenarios plus random play,
// checked every cycle against a tick-counting model of the match rules.
module tb_match_round_controller;

    localparam int RTW = 2;
    localparam int MR  = 3;
    localparam int RS  = 3;
    localparam int TPS = 2;
    localparam int IT  = 2;
    localparam int RT  = 2;
    localparam int HT  = 3;
    localparam int HWD = 9;

    logic                        clk         = 1'b0;
    logic                        reset       = 1'b0;
    logic                        tick        = 1'b0;
    logic [HWD-1:0]              health_1    = 9'd100;
    logic [HWD-1:0]              health_2    = 9'd100;
    logic                        restart_req = 1'b0;
    logic                        force_reset = 1'b0;
    logic [1:0]                  phase;
    logic                        freeze;
    logic                        round_reset;
    logic [$clog2(MR+1)-1:0]     round_num;
    logic [$clog2(RTW+1)-1:0]    wins_p1;
    logic [$clog2(RTW+1)-1:0]    wins_p2;
    logic [6:0]                  seconds_left;
    logic [1:0]                  round_winner;
    logic [1:0]                  match_winner;

    match_round_controller #(
        .ROUNDS_TO_WIN(RTW),
        .MAX_ROUNDS   (MR),
        .ROUND_SECONDS(RS),
        .TICKS_PER_SEC(TPS),
        .INTRO_TICKS  (IT),
        .RESULT_TICKS (RT),
        .HOLD_TICKS   (HT),
        .HEALTH_W     (HWD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .health_1    (health_1),
        .health_2    (health_2),
        .restart_req (restart_req),
        .force_reset (force_reset),
        .phase       (phase),
        .freeze      (freeze),
        .round_reset (round_reset),
        .round_num   (round_num),
        .wins_p1     (wins_p1),
        .wins_p2     (wins_p2),
        .seconds_left(seconds_left),
        .round_winner(round_winner),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int rr_seen = 0;

    // model state: phase, ticks spent in phase, counted fight ticks
    int m_phase, m_pticks, m_fticks, m_rn, m_w1, m_w2, m_rw, m_mw;
    int frun, rrun;
    bit m_rr;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int m_secs();
        int s;
        s = RS - m_fticks / TPS;
        return (s < 0) ? 0 : s;
    endfunction

    function void model_match_reset();
        m_phase  = 0;
        m_pticks = 0;
        m_fticks = 0;
        m_rn     = 1;
        m_w1     = 0;
        m_w2     = 0;
        m_rw     = 0;
        m_mw     = 0;
    endfunction

    function void model_hw_reset();
        model_match_reset();
        frun = 0;
        rrun = 0;
        m_rr = 0;
    endfunction

    function int cmp3(input int a, input int b);
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    function void model_tick();
        int res;
        bit ffire, rfire;
        frun  = force_reset ? frun + 1 : 0;
        ffire = (frun == HT);
        if (m_phase == 3 && restart_req) rrun++;
        else rrun = 0;
        rfire = (rrun == HT);
        if (ffire || rfire) begin
            model_match_reset();
            m_rr = 1;
            return;
        end
        case (m_phase)
            0: begin
                m_pticks++;
                if (m_pticks == IT) begin
                    m_pticks = 0;
                    m_phase  = 1;
                    m_fticks = 0;
                    m_rw     = 0;
                end
            end
            1: begin
                res = 0;
                if (health_1 == 0 && health_2 == 0) res = 3;
                else if (health_1 == 0) res = 2;
                else if (health_2 == 0) res = 1;
                else begin
                    m_fticks++;
                    if (m_fticks / TPS >= RS)
                        res = cmp3(int'(health_1), int'(health_2));
                end
                if (res != 0) begin
                    m_rw     = res;
                    m_phase  = 2;
                    m_pticks = 0;
                    if (res == 1 && m_w1 < RTW) m_w1++;
                    if (res == 2 && m_w2 < RTW) m_w2++;
                end
            end
            2: begin
                m_pticks++;
                if (m_pticks == RT) begin
                    m_pticks = 0;
                    if (m_w1 == RTW) begin
                        m_phase = 3;
                        m_mw    = 1;
                    end else if (m_w2 == RTW) begin
                        m_phase = 3;
                        m_mw    = 2;
                    end else if (m_rn == MR) begin
                        m_phase = 3;
                        m_mw    = cmp3(m_w1, m_w2);
                    end else begin
                        m_rn++;
                        m_phase = 0;
                        m_rr    = 1;
                    end
                end
            end
            default: ;
        endcase
    endfunction

    // one clock with tick = t; model advances with the same sampled inputs
    task automatic do_clk(input bit t);
        @(negedge clk);
        #1 tick = t;
        @(posedge clk);
        #1;
        m_rr = 0;
        if (!reset) model_hw_reset();
        else if (tick) model_tick();
        tick = 1'b0;
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            do_clk(1'b1);
            do_clk(1'b0);
        end
    endtask

    // every-cycle compare of all outputs against the model
    always @(negedge clk) begin
        chk("phase", int'(phase), m_phase);
        chk("freeze", int'(freeze), (m_phase != 1) ? 1 : 0);
        chk("round_reset", int'(round_reset), int'(m_rr));
        chk("round_num", int'(round_num), m_rn);
        chk("wins_p1", int'(wins_p1), m_w1);
        chk("wins_p2", int'(wins_p2), m_w2);
        chk("seconds_left", int'(seconds_left), m_secs());
        chk("round_winner", int'(round_winner), m_rw);
        chk("match_winner", int'(match_winner), m_mw);
        if (round_reset === 1'b1) rr_seen++;
    end

    initial begin
        int rr0;
        model_hw_reset();
        // ticks while reset is low do nothing
        do_clk(1'b1);
        do_clk(1'b1);
        reset = 1'b1;
        chk("pu_phase", int'(phase), 0);
        chk("pu_freeze", int'(freeze), 1);
        chk("pu_round", int'(round_num), 1);
        chk("pu_secs", int'(seconds_left), 3);
        chk("pu_rr", int'(round_reset), 0);

        tk(2);
        chk("fight_phase", int'(phase), 1);
        chk("fight_freeze", int'(freeze), 0);
        chk("fight_secs", int'(seconds_left), 3);
        tk(2);
        chk("secs_dec", int'(seconds_left), 2);

        health_2 = 9'd0;
        tk(1);
        chk("ko_rw", int'(round_winner), 1);
        chk("ko_w1", int'(wins_p1), 1);
        chk("ko_phase", int'(phase), 2);
        rr0 = rr_seen;
        tk(2);
        chk("adv_phase", int'(phase), 0);
        chk("adv_round", int'(round_num), 2);
        chk("adv_rr_pulses", rr_seen - rr0, 1);

        health_1 = 9'd80;
        health_2 = 9'd50;
        tk(2);
        tk(6);
        chk("to_rw", int'(round_winner), 1);
        chk("to_secs", int'(seconds_left), 0);
        chk("to_w1", int'(wins_p1), 2);
        tk(2);
        chk("mo_phase", int'(phase), 3);
        chk("mo_mw", int'(match_winner), 1);
        tk(3);
        chk("mo_hold", int'(phase), 3);

        restart_req = 1'b1;
        tk(2);
        chk("rs_early", int'(phase), 3);
        rr0 = rr_seen;
        tk(1);
        restart_req = 1'b0;
        chk("rs_phase", int'(phase), 0);
        chk("rs_round", int'(round_num), 1);
        chk("rs_w1", int'(wins_p1), 0);
        chk("rs_rr", rr_seen - rr0, 1);

        for (int r = 0; r < 3; r++) begin
            health_1 = 9'd100;
            health_2 = 9'd100;
            tk(2);
            health_1 = 9'd0;
            health_2 = 9'd0;
            tk(1);
            chk("dko_rw", int'(round_winner), 3);
            chk("dko_w1", int'(wins_p1), 0);
            chk("dko_w2", int'(wins_p2), 0);
            tk(2);
        end
        chk("draw_phase", int'(phase), 3);
        chk("draw_mw", int'(match_winner), 3);
        chk("draw_round", int'(round_num), 3);
        restart_req = 1'b1;
        tk(3);
        restart_req = 1'b0;

        health_1 = 9'd100;
        health_2 = 9'd100;
        tk(2);
        force_reset = 1'b1;
        tk(2);
        health_1 = 9'd0;
        tk(1);
        chk("fr_phase", int'(phase), 0);
        chk("fr_round", int'(round_num), 1);
        chk("fr_w2", int'(wins_p2), 0);
        chk("fr_rw", int'(round_winner), 0);
        force_reset = 1'b0;
        health_1 = 9'd100;
        tk(2);
        force_reset = 1'b1;
        tk(2);
        force_reset = 1'b0;
        tk(1);
        force_reset = 1'b1;
        tk(2);
        force_reset = 1'b0;
        chk("fr_broken", int'(phase), 1);

        health_2 = 9'd0;
        tk(1);
        chk("ar_pre_w1", int'(wins_p1), 1);
        tk(1);
        rr0 = rr_seen;
        #2 reset = 1'b0;
        model_hw_reset();
        #1;
        chk("ar_phase", int'(phase), 0);
        chk("ar_freeze", int'(freeze), 1);
        chk("ar_w1", int'(wins_p1), 0);
        chk("ar_secs", int'(seconds_left), 3);
        chk("ar_round", int'(round_num), 1);
        do_clk(1'b1);
        do_clk(1'b0);
        reset = 1'b1;
        chk("ar_no_rr", rr_seen - rr0, 0);
        health_2 = 9'd100;

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                health_1 = ($urandom_range(0, 5) == 0) ? 9'd0
                         : 9'(40 + 10 * $urandom_range(0, 2));
            end
            if ($urandom_range(0, 11) == 0) begin
                health_2 = ($urandom_range(0, 5) == 0) ? 9'd0
                         : 9'(40 + 10 * $urandom_range(0, 2));
            end
            if (!force_reset) force_reset = ($urandom_range(0, 299) == 0);
            else force_reset = ($urandom_range(0, 4) != 0);
            if (!restart_req) restart_req = ($urandom_range(0, 19) == 0);
            else restart_req = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b0;
                model_hw_reset();
                do_clk(1'($urandom_range(0, 1)));
                do_clk(1'($urandom_range(0, 1)));
                reset = 1'b1;
            end
            do_clk(1'($urandom_range(0, 1)));
        end
        do_clk(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
